// File: rtl/system_0_led_seq_pkg.sv
// system_0_led_seq_pkg
// Shared types and constants for the LED sequencer: FSM state encoding,
// CSR word addresses, CTRL/STATUS bit positions and the pattern-index
// advance rule.
package system_0_led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam logic [2:0] CSR_CTRL         = 3'd0;
  localparam logic [2:0] CSR_PERIOD       = 3'd1;
  localparam logic [2:0] CSR_STATUS       = 3'd2;
  localparam logic [2:0] CSR_PATTERN_BASE = 3'd4;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_LAST_LSB       = 1;
  localparam int STATUS_BUSY_BIT     = 0;
  localparam int STATUS_IDX_LSB      = 2;
  localparam int STATUS_MISMATCH_BIT = 4;

  // ">=" rather than "==" so that lowering last_idx below the live index
  // still wraps to 0 at the next step.
  function automatic logic [1:0] next_index(input logic [1:0] idx,
                                            input logic [1:0] last);
    return (idx >= last) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/system_0_led_seq_timer.sv
// system_0_led_seq_timer
// Loadable down-counter that times one sequencer step.
//   clk, reset_n : clock, async active-low reset
//   load         : reload with load_value (0 is treated as 1)
//   load_value   : step period in clocks
//   expire       : terminal count reached (count <= 1)
module system_0_led_seq_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] load_value,
  output logic                    expire
);

  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] count;

  // Loaded on the edge that enters WRITE, so the WRITE cycle itself is the
  // first cycle of the period and steps land exactly PERIOD clocks apart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= (load_value == '0) ? ONE : load_value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count <= ONE);

endmodule

// File: rtl/system_0_led_sequencer.sv
// system_0_led_sequencer
// Autonomous LED pattern sequencer. Holds NUM_PATTERNS patterns and a step
// period written over the CSR slave port and drives the LED PIO s1 port as
// its only master, writing the next pattern every PERIOD clocks.
// Optional build macro: LEDSEQ_VERIFY_EN adds a read-back VERIFY cycle after
// each write and a sticky mismatch flag in STATUS[4].
// Ports:
//   clk, reset_n                         : clock, async active-low reset
//   address/chipselect/write_n/writedata : CSR write side
//   readdata                             : CSR read data (combinational)
//   pio_address/pio_chipselect/pio_write_n/pio_writedata : PIO s1 master
//   pio_readdata                         : PIO s1 read data (verify only)
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | stopped; waits for CTRL.enable
// ST_WRITE  | one-cycle PIO write of PATTERN[index]
// ST_VERIFY | one-cycle PIO read-back compare (LEDSEQ_VERIFY_EN)
// ST_WAIT   | counting out the rest of the step period
module system_0_led_sequencer
  import system_0_led_seq_pkg::*;
#(
  parameter int LED_WIDTH    = 10,
  parameter int PERIOD_WIDTH = 24,
  parameter int NUM_PATTERNS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata
);

`ifdef LEDSEQ_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  localparam logic [1:0] LAST_MAX = 2'(NUM_PATTERNS - 1);
  localparam logic [2:0] PAT_CNT  = 3'(NUM_PATTERNS);

  logic                    enable;
  logic [1:0]              last_idx;
  logic [PERIOD_WIDTH-1:0] period;
  logic [LED_WIDTH-1:0]    pattern [NUM_PATTERNS];
  logic                    mismatch;

  state_t                  state;
  logic [1:0]              index;
  logic [LED_WIDTH-1:0]    pio_led;

  logic                    csr_we;
  logic                    pattern_hit;
  logic                    timer_expire;
  logic                    step_point;
  logic                    go_write;
  logic                    go_idle;
  logic [1:0]              next_idx;

  assign csr_we      = chipselect && !write_n;
  assign pattern_hit = address[2] && ({1'b0, address[1:0]} < PAT_CNT);

  // ---------------- CSR registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      last_idx <= 2'd0;
      period   <= '0;
      for (int i = 0; i < NUM_PATTERNS; i++) pattern[i] <= '0;
    end else if (csr_we) begin
      if (address == CSR_CTRL) begin
        enable   <= writedata[CTRL_ENABLE_BIT];
        last_idx <= ({1'b0, writedata[CTRL_LAST_LSB +: 2]} > {1'b0, LAST_MAX})
                    ? LAST_MAX : writedata[CTRL_LAST_LSB +: 2];
      end
      if (address == CSR_PERIOD) period <= writedata[PERIOD_WIDTH-1:0];
      if (pattern_hit) pattern[address[1:0]] <= writedata[LED_WIDTH-1:0];
    end
  end

  logic unused_pio_rd;
  logic unused_wd;
  assign unused_wd = ^writedata[31:PERIOD_WIDTH];

`ifdef LEDSEQ_VERIFY_EN
  logic verify_fail;
  // pio_led still holds the value written in the preceding WRITE cycle.
  assign verify_fail = (state == ST_VERIFY) &&
                       (pio_readdata[LED_WIDTH-1:0] != pio_led);

  // A mismatch in the same cycle as a write-1-clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch <= 1'b0;
    end else if (verify_fail) begin
      mismatch <= 1'b1;
    end else if (csr_we && (address == CSR_STATUS) &&
                 writedata[STATUS_MISMATCH_BIT]) begin
      mismatch <= 1'b0;
    end
  end
  assign unused_pio_rd = ^pio_readdata[31:LED_WIDTH];
`else
  assign mismatch      = 1'b0;
  assign unused_pio_rd = ^pio_readdata;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      CSR_CTRL: begin
        readdata[CTRL_ENABLE_BIT]      = enable;
        readdata[CTRL_LAST_LSB +: 2]   = last_idx;
      end
      CSR_PERIOD: readdata[PERIOD_WIDTH-1:0] = period;
      CSR_STATUS: begin
        readdata[STATUS_BUSY_BIT]      = (state != ST_IDLE);
        readdata[STATUS_IDX_LSB +: 2]  = index;
        readdata[STATUS_MISMATCH_BIT]  = mismatch;
      end
      default: begin
        if (pattern_hit) readdata[LED_WIDTH-1:0] = pattern[address[1:0]];
      end
    endcase
  end

  // ---------------- step control ----------------
  // A step decision is taken in WAIT, in VERIFY, and in WRITE when there is
  // no VERIFY cycle; this is what lets PERIOD=1 give back-to-back writes.
  always_comb begin
    step_point = (state == ST_WAIT) || (state == ST_VERIFY) ||
                 ((state == ST_WRITE) && !VERIFY_EN);
    go_write   = ((state == ST_IDLE) && enable) ||
                 (step_point && enable && timer_expire);
    go_idle    = step_point && !enable;
    next_idx   = (state == ST_IDLE) ? 2'd0 : next_index(index, last_idx);
  end

  system_0_led_seq_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (go_write),
    .load_value (period),
    .expire     (timer_expire)
  );

  // ---------------- FSM with registered PIO outputs ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      index          <= 2'd0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_led        <= '0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      if (go_write) begin
        state          <= ST_WRITE;
        index          <= next_idx;
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_led        <= pattern[next_idx];
      end else if (go_idle) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_WRITE: begin
            if (VERIFY_EN) begin
              state          <= ST_VERIFY;
              pio_chipselect <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
          ST_VERIFY: state <= ST_WAIT;
          default: ;
        endcase
      end
    end
  end

  assign pio_address   = 2'b00;
  assign pio_writedata = {{(32-LED_WIDTH){1'b0}}, pio_led};

endmodule

// File: tb/tb_system_0_led_sequencer.sv
`timescale 1ns/1ps
module tb_system_0_led_sequencer;

  localparam int LW = 10;
`ifdef LEDSEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = 3'd2;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  logic [LW-1:0] pio_reg = '0;
  bit            force_bad = 1'b0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  idx;
    bit          idx_ok;
  } wr_t;
  wr_t wq[$];

  system_0_led_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LED PIO model: data register written by s1, read back combinationally.
  always @(posedge clk)
    if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata[LW-1:0];
  assign pio_readdata = force_bad ? 32'h155 : {{(32-LW){1'b0}}, pio_reg};

  // Record every PIO write with its cycle and the STATUS index shown then.
  always @(negedge clk) begin
    wr_t e;
    if (pio_chipselect && !pio_write_n) begin
      e.cyc    = cyc;
      e.data   = pio_writedata;
      e.idx    = readdata[3:2];
      e.idx_ok = (address == 3'd2);
      wq.push_back(e);
    end
  end

  // Reference: spacing between writes from the period rule.
  function automatic int model_gap(input int per);
    int g;
    g = (per == 0) ? 1 : per;
    if (VERIFY && g < 2) g = 2;
    return g;
  endfunction

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd2; writedata = '0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a;
    #2 d = readdata;
    address = 3'd2;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wq.size() >= n) break;
    end
  endtask

  task automatic stop_run();
    csr_write(3'd0, 32'h0);
    repeat (4) @(posedge clk);
    wq.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (pio_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b expected 0", pio_chipselect); end
    n_cmp++; if (pio_write_n !== 1'b1) begin n_fail++; $display("FAIL rst_wn: got %b expected 1", pio_write_n); end
    n_cmp++; if (pio_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wd: got %h expected 0", pio_writedata); end
    n_cmp++; if (pio_address !== 2'b00) begin n_fail++; $display("FAIL rst_addr: got %b expected 0", pio_address); end
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), r);
      n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_csr[%0d]: got %h expected 0", a, r); end
    end
  endtask

  task automatic test_sequence();
    logic [LW-1:0] p [4];
    logic [31:0]   r;
    p[0] = 10'h001; p[1] = 10'h002; p[2] = 10'h004; p[3] = 10'h3FF;
    for (int i = 0; i < 4; i++) csr_write(3'(4 + i), {22'b0, p[i]});
    csr_write(3'd1, 32'd5);
    wq.delete();
    csr_write(3'd0, 32'h7);
    wait_writes(5, 200);
    n_cmp++;
    if (wq.size() < 5) begin
      n_fail++; $display("FAIL seq_timeout: got %0d writes expected 5", wq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (wq[k].data !== {22'b0, p[k % 4]}) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", k, wq[k].data, p[k % 4]); end
        if (wq[k].idx_ok) begin
          n_cmp++;
          if (wq[k].idx !== 2'(k % 4)) begin n_fail++; $display("FAIL seq_idx[%0d]: got %0d expected %0d", k, wq[k].idx, k % 4); end
        end
        if (k > 0) begin
          n_cmp++;
          if (wq[k].cyc - wq[k-1].cyc != model_gap(5)) begin n_fail++; $display("FAIL seq_gap[%0d]: got %0d expected %0d", k, wq[k].cyc - wq[k-1].cyc, model_gap(5)); end
        end
      end
    end
    csr_read(3'd2, r);
    n_cmp++; if (r[4] !== 1'b0) begin n_fail++; $display("FAIL seq_nomismatch: got %b expected 0", r[4]); end
    n_cmp++; if (r[0] !== 1'b1) begin n_fail++; $display("FAIL seq_busy: got %b expected 1", r[0]); end
    stop_run();
  endtask

  task automatic test_clamp_wrap();
    csr_write(3'd1, 32'd0);
    wq.delete();
    csr_write(3'd0, 32'h3);
    wait_writes(8, 100);
    n_cmp++;
    if (wq.size() < 8) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d writes expected 8", wq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (wq[k].data !== ((k % 2) ? 32'h002 : 32'h001)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, wq[k].data, (k % 2) ? 2 : 1); end
        if (wq[k].idx_ok) begin
          n_cmp++;
          if (wq[k].idx !== 2'(k % 2)) begin n_fail++; $display("FAIL wrap_idx[%0d]: got %0d expected %0d", k, wq[k].idx, k % 2); end
        end
        if (k > 0) begin
          n_cmp++;
          if (wq[k].cyc - wq[k-1].cyc != model_gap(0)) begin n_fail++; $display("FAIL wrap_gap[%0d]: got %0d expected %0d", k, wq[k].cyc - wq[k-1].cyc, model_gap(0)); end
        end
      end
    end
    stop_run();
  endtask

  task automatic test_disable();
    logic [31:0] r;
    csr_write(3'd1, 32'd20);
    wq.delete();
    csr_write(3'd0, 32'h7);
    wait_writes(2, 100);
    n_cmp++; if (wq.size() < 2) begin n_fail++; $display("FAIL dis_timeout: got %0d writes expected 2", wq.size()); end
    repeat (3) @(posedge clk);
    csr_write(3'd0, 32'h6);
    csr_read(3'd2, r);
    n_cmp++; if (r[0] !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b expected 0", r[0]); end
    repeat (60) @(negedge clk);
    n_cmp++; if (wq.size() != 2) begin n_fail++; $display("FAIL dis_nowrite: got %0d writes expected 2", wq.size()); end
    n_cmp++; if (pio_reg !== 10'h002) begin n_fail++; $display("FAIL dis_hold: got %h expected 002", pio_reg); end
    stop_run();
  endtask

  task automatic test_verify();
    logic [31:0] r;
    csr_write(3'd4, 32'h3FF);
    csr_write(3'd1, 32'd30);
    csr_write(3'd2, 32'h10);
    force_bad = 1'b1;
    wq.delete();
    csr_write(3'd0, 32'h1);
    wait_writes(1, 50);
    n_cmp++; if (wq.size() < 1) begin n_fail++; $display("FAIL ver_timeout: got %0d writes expected 1", wq.size()); end
    csr_write(3'd2, 32'h10);   // lands in the VERIFY cycle
    csr_read(3'd2, r);
    n_cmp++; if (r[4] !== VERIFY) begin n_fail++; $display("FAIL ver_set_wins: got %b expected %b", r[4], VERIFY); end
    csr_write(3'd2, 32'h10);
    csr_read(3'd2, r);
    n_cmp++; if (r[4] !== 1'b0) begin n_fail++; $display("FAIL ver_clear: got %b expected 0", r[4]); end
    wait_writes(2, 60);
    n_cmp++; if (wq.size() < 2) begin n_fail++; $display("FAIL ver_timeout2: got %0d writes expected 2", wq.size()); end
    repeat (3) @(posedge clk);
    csr_read(3'd2, r);
    n_cmp++; if (r[4] !== VERIFY) begin n_fail++; $display("FAIL ver_set: got %b expected %b", r[4], VERIFY); end
    stop_run();
    force_bad = 1'b0;
    csr_write(3'd2, 32'h10);
    csr_read(3'd2, r);
    n_cmp++; if (r[4] !== 1'b0) begin n_fail++; $display("FAIL ver_clear2: got %b expected 0", r[4]); end
  endtask

  task automatic test_live_update();
    csr_write(3'd4, 32'h001); csr_write(3'd5, 32'h002);
    csr_write(3'd6, 32'h004); csr_write(3'd7, 32'h008);
    csr_write(3'd1, 32'd20);
    wq.delete();
    csr_write(3'd0, 32'h7);
    wait_writes(1, 50);
    csr_write(3'd5, 32'h2AA);
    wait_writes(3, 100);
    n_cmp++;
    if (wq.size() < 3) begin
      n_fail++; $display("FAIL live_timeout: got %0d writes expected 3", wq.size());
    end else begin
      n_cmp++; if (wq[0].data !== 32'h001) begin n_fail++; $display("FAIL live_w0: got %h expected 001", wq[0].data); end
      n_cmp++; if (wq[1].data !== 32'h2AA) begin n_fail++; $display("FAIL live_w1: got %h expected 2aa", wq[1].data); end
      n_cmp++; if (wq[2].data !== 32'h004) begin n_fail++; $display("FAIL live_w2: got %h expected 004", wq[2].data); end
    end
    stop_run();
  endtask

  task automatic test_random();
    logic [LW-1:0] p [4];
    logic [31:0]   r;
    int last, per, n;
    for (int it = 0; it < 6; it++) begin
      last = $urandom_range(0, 3);
      per  = $urandom_range(0, 12);
      n    = 7;
      for (int i = 0; i < 4; i++) begin
        p[i] = LW'($urandom_range(0, 1023));
        csr_write(3'(4 + i), {22'b0, p[i]});
      end
      csr_write(3'd1, 32'(per));
      wq.delete();
      csr_write(3'd0, 32'((last << 1) | 1));
      wait_writes(n, n * 16 + 20);
      n_cmp++;
      if (wq.size() < n) begin
        n_fail++; $display("FAIL rnd_timeout[%0d]: got %0d writes expected %0d", it, wq.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          n_cmp++;
          if (wq[k].data !== {22'b0, p[k % (last + 1)]}) begin n_fail++; $display("FAIL rnd_data[%0d.%0d]: got %h expected %h", it, k, wq[k].data, p[k % (last + 1)]); end
          if (wq[k].idx_ok) begin
            n_cmp++;
            if (wq[k].idx !== 2'(k % (last + 1))) begin n_fail++; $display("FAIL rnd_idx[%0d.%0d]: got %0d expected %0d", it, k, wq[k].idx, k % (last + 1)); end
          end
          if (k > 0) begin
            n_cmp++;
            if (wq[k].cyc - wq[k-1].cyc != model_gap(per)) begin n_fail++; $display("FAIL rnd_gap[%0d.%0d]: got %0d expected %0d", it, k, wq[k].cyc - wq[k-1].cyc, model_gap(per)); end
          end
        end
      end
      csr_read(3'd1, r);
      n_cmp++; if (r !== 32'(per)) begin n_fail++; $display("FAIL rnd_period_rb[%0d]: got %h expected %h", it, r, per); end
      csr_read(3'd0, r);
      n_cmp++; if (r !== 32'((last << 1) | 1)) begin n_fail++; $display("FAIL rnd_ctrl_rb[%0d]: got %h expected %h", it, r, (last << 1) | 1); end
      stop_run();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] r;
    csr_write(3'd4, 32'h155);
    csr_write(3'd1, 32'd50);
    wq.delete();
    csr_write(3'd0, 32'h7);
    wait_writes(1, 50);
    n_cmp++; if (wq.size() < 1) begin n_fail++; $display("FAIL mrst_timeout: got %0d writes expected 1", wq.size()); end
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (pio_chipselect !== 1'b0) begin n_fail++; $display("FAIL mrst_cs: got %b expected 0", pio_chipselect); end
    n_cmp++; if (pio_write_n !== 1'b1) begin n_fail++; $display("FAIL mrst_wn: got %b expected 1", pio_write_n); end
    n_cmp++; if (pio_writedata !== 32'h0) begin n_fail++; $display("FAIL mrst_wd: got %h expected 0", pio_writedata); end
    csr_read(3'd2, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mrst_status: got %h expected 0", r); end
    csr_read(3'd0, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mrst_ctrl: got %h expected 0", r); end
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (wq.size() != 1) begin n_fail++; $display("FAIL mrst_nowrite: got %0d writes expected 1", wq.size()); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_clamp_wrap();
    test_disable();
    test_verify();
    test_live_update();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
